// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester data-RAM arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned STRB_W        = 4;
    localparam int unsigned DEF_MEM_DEPTH = 16384;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } mem_req_t;

    // Request payload of the granted requester.
    function automatic mem_req_t pick_req(input logic gnt_id, input mem_req_t req0,
                                          input mem_req_t req1);
        return (gnt_id == GNT_M1) ? req1 : req0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; the caller owns last_grant.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_gnt_valid_c,
    output logic       o_gnt_id_c
);

    assign o_gnt_valid_c = |i_req;

    // On contention the requester that was not served last wins.
    always_comb begin
        o_gnt_id_c = GNT_M0;
        if (i_req == 2'b11) begin
            o_gnt_id_c = ~i_last_grant;
        end else if (i_req[1]) begin
            o_gnt_id_c = GNT_M1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer placing two valid/done requesters onto a
// single-port synchronous RAM; one access at a time, IDLE->ISSUE->WAIT->DONE.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         m0_valid_i,
    input  logic                         m0_wen_i,
    input  logic [31:0]                  m0_addr_i,
    input  logic [31:0]                  m0_wdata_i,
    input  logic [3:0]                   m0_strb_i,
    output logic [31:0]                  m0_rdata_o,
    output logic                         m0_done_o,

    input  logic                         m1_valid_i,
    input  logic                         m1_wen_i,
    input  logic [31:0]                  m1_addr_i,
    input  logic [31:0]                  m1_wdata_i,
    input  logic [3:0]                   m1_strb_i,
    output logic [31:0]                  m1_rdata_o,
    output logic                         m1_done_o,

    output logic                         ram_en_o,
    output logic                         ram_wen_o,
    output logic [$clog2(MEM_DEPTH)-1:0] ram_addr_o,
    output logic [31:0]                  ram_wdata_o,
    output logic [3:0]                   ram_wstrb_o,
    input  logic [31:0]                  ram_rdata_i
);

    localparam int unsigned RAM_AW = $clog2(MEM_DEPTH);

    state_e             r_state,      w_state;
    logic               r_last_grant, w_last_grant;
    logic               r_gnt_id,     w_gnt_id;
    logic               r_wen,        w_wen;
    logic               r_ram_en,     w_ram_en;
    logic               r_ram_wen,    w_ram_wen;
    logic [RAM_AW-1:0]  r_ram_addr,   w_ram_addr;
    logic [DATA_W-1:0]  r_ram_wdata,  w_ram_wdata;
    logic [STRB_W-1:0]  r_ram_wstrb,  w_ram_wstrb;
    logic [DATA_W-1:0]  r_m0_rdata,   w_m0_rdata;
    logic [DATA_W-1:0]  r_m1_rdata,   w_m1_rdata;
    logic               r_m0_done,    w_m0_done;
    logic               r_m1_done,    w_m1_done;

    mem_req_t           w_m0_req;
    mem_req_t           w_m1_req;
    mem_req_t           w_sel_req;
    logic               w_arb_valid;
    logic               w_arb_id;
    logic               w_unused_addr;

    assign w_m0_req  = {m0_wen_i, m0_addr_i, m0_wdata_i, m0_strb_i};
    assign w_m1_req  = {m1_wen_i, m1_addr_i, m1_wdata_i, m1_strb_i};
    assign w_sel_req = pick_req(w_arb_id, w_m0_req, w_m1_req);

    // Byte offset and bits above the RAM range are dropped: accesses wrap.
    assign w_unused_addr = ^{w_sel_req.addr[ADDR_W-1:RAM_AW+2], w_sel_req.addr[1:0]};

    rr_arbiter2 u_rr_arbiter2 (
        .i_req         ({m1_valid_i, m0_valid_i}),
        .i_last_grant  (r_last_grant),
        .o_gnt_valid_c (w_arb_valid),
        .o_gnt_id_c    (w_arb_id)
    );

    // Next-state and next-output logic; every output is a registered copy.
    always_comb begin
        w_state      = r_state;
        w_last_grant = r_last_grant;
        w_gnt_id     = r_gnt_id;
        w_wen        = r_wen;
        w_ram_en     = 1'b0;
        w_ram_wen    = 1'b0;
        w_ram_addr   = r_ram_addr;
        w_ram_wdata  = r_ram_wdata;
        w_ram_wstrb  = r_ram_wstrb;
        w_m0_rdata   = r_m0_rdata;
        w_m1_rdata   = r_m1_rdata;
        w_m0_done    = 1'b0;
        w_m1_done    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state      = ST_ISSUE;
                    w_gnt_id     = w_arb_id;
                    w_last_grant = w_arb_id;
                    w_wen        = w_sel_req.wen;
                    w_ram_en     = 1'b1;
                    w_ram_wen    = w_sel_req.wen;
                    w_ram_addr   = w_sel_req.addr[RAM_AW+1:2];
                    w_ram_wdata  = w_sel_req.wdata;
                    w_ram_wstrb  = w_sel_req.wen ? w_sel_req.strb : STRB_W'(0);
                end
            end
            ST_ISSUE: begin
                w_state = ST_WAIT;
            end
            ST_WAIT: begin
                // RAM data is valid this cycle; done lands in DONE.
                if (!r_wen) begin
                    if (r_gnt_id == GNT_M1) begin
                        w_m1_rdata = ram_rdata_i;
                    end else begin
                        w_m0_rdata = ram_rdata_i;
                    end
                end
                w_m0_done = (r_gnt_id == GNT_M0);
                w_m1_done = (r_gnt_id == GNT_M1);
                w_state   = ST_DONE;
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GNT_M1;
            r_gnt_id     <= GNT_M0;
            r_wen        <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_wen    <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_wstrb  <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_done    <= 1'b0;
            r_m1_done    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last_grant <= w_last_grant;
            r_gnt_id     <= w_gnt_id;
            r_wen        <= w_wen;
            r_ram_en     <= w_ram_en;
            r_ram_wen    <= w_ram_wen;
            r_ram_addr   <= w_ram_addr;
            r_ram_wdata  <= w_ram_wdata;
            r_ram_wstrb  <= w_ram_wstrb;
            r_m0_rdata   <= w_m0_rdata;
            r_m1_rdata   <= w_m1_rdata;
            r_m0_done    <= w_m0_done;
            r_m1_done    <= w_m1_done;
        end
    end

    assign ram_en_o    = r_ram_en;
    assign ram_wen_o   = r_ram_wen;
    assign ram_addr_o  = r_ram_addr;
    assign ram_wdata_o = r_ram_wdata;
    assign ram_wstrb_o = r_ram_wstrb;
    assign m0_rdata_o  = r_m0_rdata;
    assign m0_done_o   = r_m0_done;
    assign m1_rdata_o  = r_m1_rdata;
    assign m1_done_o   = r_m1_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level memory model plus
// directed scenarios and randomized two-requester traffic.
module tb_dmem_arbiter;

    localparam int unsigned MEM_DEPTH = 16384;
    localparam int unsigned AW        = $clog2(MEM_DEPTH);

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          m0_valid_i = 1'b0, m0_wen_i = 1'b0;
    logic [31:0]   m0_addr_i = '0, m0_wdata_i = '0;
    logic [3:0]    m0_strb_i = '0;
    logic [31:0]   m0_rdata_o;
    logic          m0_done_o;
    logic          m1_valid_i = 1'b0, m1_wen_i = 1'b0;
    logic [31:0]   m1_addr_i = '0, m1_wdata_i = '0;
    logic [3:0]    m1_strb_i = '0;
    logic [31:0]   m1_rdata_o;
    logic          m1_done_o;
    logic          ram_en_o, ram_wen_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [3:0]    ram_wstrb_o;
    logic [31:0]   ram_rdata_i = '0;

    dmem_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_valid_i(m0_valid_i), .m0_wen_i(m0_wen_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_strb_i(m0_strb_i),
        .m0_rdata_o(m0_rdata_o), .m0_done_o(m0_done_o),
        .m1_valid_i(m1_valid_i), .m1_wen_i(m1_wen_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_strb_i(m1_strb_i),
        .m1_rdata_o(m1_rdata_o), .m1_done_o(m1_done_o),
        .ram_en_o(ram_en_o), .ram_wen_o(ram_wen_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_wstrb_o(ram_wstrb_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic wen; logic [31:0] rdata; } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int          done_log[$];
    logic [31:0] model_mem [MEM_DEPTH];
    logic [31:0] ram [MEM_DEPTH];
    logic [31:0] last_rd0 = '0, last_rd1 = '0;
    logic        prev_en = 1'b0;
    int          ram_en_cnt = 0;
    logic [31:0] last_ram_addr = '0;
    logic [3:0]  last_ram_wstrb = '0;
    logic        bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Environment RAM: one-cycle synchronous read, byte-strobed write, backdoor preload.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (ram_en_o) begin
            if (ram_wen_o) ram[ram_addr_o] <= merge(ram[ram_addr_o], ram_wdata_o, ram_wstrb_o);
            ram_rdata_i <= ram[ram_addr_o];
        end
    end

    task automatic preload(input int word, input logic [31:0] data);
        bd_we = 1'b1; bd_addr = AW'(word); bd_data = data;
        model_mem[word] = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic set_req(input int id, input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (id == 0) begin
            m0_valid_i = v; m0_wen_i = w; m0_addr_i = a; m0_wdata_i = d; m0_strb_i = s;
        end else begin
            m1_valid_i = v; m1_wen_i = w; m1_addr_i = a; m1_wdata_i = d; m1_strb_i = s;
        end
    endtask

    // One transaction; called at posedge+1, returns at posedge+1 with valid low.
    task automatic drive(input int id, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, output int lat);
        exp_t e;
        int   word;
        int   start;
        logic seen;
        word = int'((addr >> 2) % 32'(MEM_DEPTH));
        if (wen) model_mem[word] = merge(model_mem[word], wdata, strb);
        e.wen = wen;
        e.rdata = model_mem[word];
        if (id == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        set_req(id, 1'b1, wen, addr, wdata, strb);
        start = cyc;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = (id == 0) ? m0_done_o : m1_done_o;
            if (seen) begin
                lat = cyc - start;
                break;
            end
        end
        n_checks++;
        if (lat < 0) begin
            n_errors++;
            $display("FAIL m%0d_done_timeout: no done within 40 cycles", id);
        end else if (lat < 3 || lat > 7) begin
            n_errors++;
            $display("FAIL m%0d_latency: got %0d cycles expected 3..7", id, lat);
        end
        @(posedge clk); #1;
        if (id == 0) m0_valid_i = 1'b0; else m1_valid_i = 1'b0;
    endtask

    // Monitor: pops expectations on each done pulse and checks RAM-side rules.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (ram_en_o) begin
                    ram_en_cnt++;
                    last_ram_addr  = 32'(ram_addr_o);
                    last_ram_wstrb = ram_wstrb_o;
                    check32("ram_en_single_cycle", 32'(prev_en), 32'd0);
                    if (!ram_wen_o) check32("read_wstrb_zero", 32'(ram_wstrb_o), 32'd0);
                end
                if (m0_done_o || m1_done_o)
                    check32("dual_done", 32'(m0_done_o & m1_done_o), 32'd0);
                if (m0_done_o) begin
                    done_log.push_back(0);
                    n_checks++;
                    if (exp_q0.size() == 0) begin
                        n_errors++;
                        $display("FAIL m0_unexpected_done: done with no request outstanding");
                    end else begin
                        e = exp_q0.pop_front();
                        if (!e.wen) last_rd0 = e.rdata;
                        check32("m0_rdata", m0_rdata_o, last_rd0);
                        check32("m1_rdata_hold", m1_rdata_o, last_rd1);
                    end
                end
                if (m1_done_o) begin
                    done_log.push_back(1);
                    n_checks++;
                    if (exp_q1.size() == 0) begin
                        n_errors++;
                        $display("FAIL m1_unexpected_done: done with no request outstanding");
                    end else begin
                        e = exp_q1.pop_front();
                        if (!e.wen) last_rd1 = e.rdata;
                        check32("m1_rdata", m1_rdata_o, last_rd1);
                        check32("m0_rdata_hold", m0_rdata_o, last_rd0);
                    end
                end
            end
            prev_en = ram_en_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, lat1, k, cnt0;
        for (int i = 0; i < int'(MEM_DEPTH); i++) model_mem[i] = '0;

        // Reset with backdoor preload of the words used below.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) preload(i, 32'h5A000000 | 32'(i * 32'h01010101));
        preload(32'h10, 32'hDEADBEEF);
        preload(32'h11, 32'h11223344);
        @(negedge clk);
        check32("reset_done", 32'({m0_done_o, m1_done_o}), 32'd0);
        check32("reset_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
        check32("reset_ram", 32'({ram_en_o, ram_wen_o, ram_wstrb_o}) | 32'(ram_addr_o) | ram_wdata_o, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single read of byte address 0x40.
        cnt0 = ram_en_cnt;
        drive(0, 1'b0, 32'h40, 32'h0, 4'hF, lat0);
        check32("single_read_latency", 32'(lat0), 32'd3);
        check32("single_read_en_count", 32'(ram_en_cnt - cnt0), 32'd1);
        check32("single_read_ram_addr", last_ram_addr, 32'h10);
        check32("single_read_wstrb", 32'(last_ram_wstrb), 32'd0);

        // Byte write then read from m1.
        drive(1, 1'b1, 32'h44, 32'h000000AA, 4'b0001, lat1);
        drive(1, 1'b0, 32'h44, 32'h0, 4'h0, lat1);
        check32("byte_merge_value", m1_rdata_o, 32'h112233AA);
        check32("byte_merge_m0_hold", m0_rdata_o, 32'hDEADBEEF);

        // First contention: m0 wins, m1 follows four cycles later.
        done_log.delete();
        fork
            drive(0, 1'b0, 32'h0C, 32'h0, 4'h0, lat0);
            drive(1, 1'b0, 32'h84, 32'h0, 4'h0, lat1);
        join
        check32("contention_m0_latency", 32'(lat0), 32'd3);
        check32("contention_m1_latency", 32'(lat1), 32'd7);
        check32("contention_log_size", 32'(done_log.size()), 32'd2);
        if (done_log.size() == 2) begin
            check32("contention_first", 32'(done_log[0]), 32'd0);
            check32("contention_second", 32'(done_log[1]), 32'd1);
        end

        // Continuous contention: strict alternation starting with m0.
        done_log.delete();
        fork
            for (int i = 0; i < 3; i++) drive(0, 1'(i % 2), 32'(4 * (20 + i)), $urandom, 4'hF, lat0);
            for (int i = 0; i < 3; i++) drive(1, 1'(i % 2), 32'(4 * (40 + i)), $urandom, 4'hF, lat1);
        join
        check32("rr_log_size", 32'(done_log.size()), 32'd6);
        for (int i = 0; i < done_log.size(); i++)
            check32($sformatf("rr_order_%0d", i), 32'(done_log[i]), 32'(i % 2));

        // Address wrap above the RAM range.
        drive(0, 1'b1, 32'(MEM_DEPTH * 4 + 8), 32'h12345678, 4'hF, lat0);
        check32("wrap_ram_addr", last_ram_addr, 32'd2);
        drive(0, 1'b0, 32'h8, 32'h0, 4'h0, lat0);
        check32("wrap_read_value", m0_rdata_o, 32'h12345678);

        // Randomized traffic, each requester in its own 32-word region.
        fork
            for (int i = 0; i < 40; i++) begin
                int w; logic [31:0] a;
                w = int'($urandom_range(31));
                a = 32'($urandom_range(255)) * 32'(MEM_DEPTH * 4) + 32'(w * 4) + 32'($urandom_range(3));
                drive(0, 1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)), lat0);
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
            end
            for (int i = 0; i < 40; i++) begin
                int w; logic [31:0] a;
                w = 32 + int'($urandom_range(31));
                a = 32'($urandom_range(255)) * 32'(MEM_DEPTH * 4) + 32'(w * 4) + 32'($urandom_range(3));
                drive(1, 1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)), lat1);
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
            end
        join
        check32("random_q0_drained", 32'(exp_q0.size()), 32'd0);
        check32("random_q1_drained", 32'(exp_q1.size()), 32'd0);

        // Reset during WAIT of an m0 read: no done, all outputs cleared.
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h40, 32'hCAFE0000, 4'hF);
        k = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b1;
        m0_valid_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check32("midrst_cycle", 32'(cyc - k), 32'd3);
        check32("midrst_done", 32'({m0_done_o, m1_done_o}), 32'd0);
        check32("midrst_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
        check32("midrst_ram", 32'({ram_en_o, ram_wen_o, ram_wstrb_o}) | 32'(ram_addr_o) | ram_wdata_o, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        last_rd0 = '0;
        last_rd1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("midrst_no_late_done", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        // After reset m0 again wins contention.
        done_log.delete();
        fork
            drive(0, 1'b0, 32'h40, 32'h0, 4'h0, lat0);
            drive(1, 1'b0, 32'h44, 32'h0, 4'h0, lat1);
        join
        check32("post_rst_log_size", 32'(done_log.size()), 32'd2);
        if (done_log.size() == 2) begin
            check32("post_rst_first", 32'(done_log[0]), 32'd0);
            check32("post_rst_second", 32'(done_log[1]), 32'd1);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
